mem_access_ctrl: RTL and testbench

Memory access sequencer for the 8085 datapath. It arbitrates between the instruction-fetch requester and the data-access requester and loads the MAR. It drives the MBR direction/enable controls (`data_src`, `en_read`, `en`) and strobes the RAM so that one byte moves per granted request. It sits between the control unit and the MAR/MBR/RAM trio, and it is the only block that drives MBR controls.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_rr_arb.sv | 35 +++
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the memory access sequencer.
//   state_t   : sequencer states (WAIT is only reachable when the
//               MEM_WAIT_STATE_EN build macro is defined)
//   GNT_FETCH : grant index of the instruction-fetch requester
//   GNT_DATA  : grant index of the data-access requester
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        XFER  = 3'd3,
        DRIVE = 3'd4
    } state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/mem_rr_arb.sv
// ---------------------------------------------------------------------------
// mem_rr_arb
// Two-way round-robin arbiter, purely combinational. The last-grant flop
// lives in the parent so the arbiter itself holds no state.
// Ports:
//   fetch_req  in  : instruction-fetch request
//   data_req   in  : data-access request
//   last_grant in  : requester granted most recently (GNT_FETCH/GNT_DATA)
//   grant      out : index of the winning requester
//   valid      out : at least one request is pending
// ---------------------------------------------------------------------------
module mem_rr_arb
    import mem_ctrl_pkg::*;
(
    input  logic fetch_req,
    input  logic data_req,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        grant = GNT_FETCH;
        valid = fetch_req | data_req;
        if (fetch_req && data_req) begin
            // Contention: the requester that did not win last time goes now.
            grant = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (data_req) begin
            grant = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Memory access sequencer: arbitrates fetch vs data requests, loads the MAR,
// steers the MBR and strobes the RAM so one byte moves per granted request.
// Sequence: IDLE -> ADDR -> [WAIT] -> XFER -> DRIVE -> IDLE.
// Build option: define MEM_WAIT_STATE_EN to insert a WAIT state between
// ADDR and XFER (ram_rd asserted early for reads).
// Ports:
//   clk, reset (async, active-low)
//   fetch_req/fetch_addr          : read-only fetch requester
//   data_req/data_we/data_addr    : read/write data requester
//   fetch_ack, data_ack           : one-cycle completion pulses
//   mar_addr, mar_load            : MAR address and load strobe
//   mbr_data_src, mbr_en_read,
//   mbr_en                        : MBR side select / direction / enable
//   ram_rd, ram_wr                : RAM strobes
//   busy                          : high whenever the sequencer is not IDLE
// All outputs are registered decodes of the state being entered.
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    output logic              fetch_ack,
    output logic              data_ack,
    output logic [ADDR_W-1:0] mar_addr,
    output logic              mar_load,
    output logic              mbr_data_src,
    output logic              mbr_en_read,
    output logic              mbr_en,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic              busy
);

    state_t state;
    logic   grant_q;     // owner of the cycle in flight
    logic   we_q;        // direction of the cycle in flight, sampled in IDLE
    logic   last_grant;  // round-robin history
    logic   arb_grant;
    logic   arb_valid;

    mem_rr_arb u_arb (
        .fetch_req  (fetch_req),
        .data_req   (data_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            grant_q      <= GNT_FETCH;
            we_q         <= 1'b0;
            last_grant   <= GNT_DATA;   // fetch wins the first contention
            mar_addr     <= '0;
            mar_load     <= 1'b0;
            mbr_data_src <= 1'b0;
            mbr_en_read  <= 1'b1;
            mbr_en       <= 1'b0;
            ram_rd       <= 1'b0;
            ram_wr       <= 1'b0;
            fetch_ack    <= 1'b0;
            data_ack     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the
            // defaults below are overridden by the later per-state writes.
            mar_load     <= 1'b0;
            mbr_data_src <= 1'b0;
            mbr_en_read  <= 1'b1;
            mbr_en       <= 1'b0;
            ram_rd       <= 1'b0;
            ram_wr       <= 1'b0;
            fetch_ack    <= 1'b0;
            data_ack     <= 1'b0;
            busy         <= 1'b1;

            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state    <= ADDR;
                        grant_q  <= arb_grant;
                        // Fetches are always reads.
                        we_q     <= (arb_grant == GNT_DATA) ? data_we : 1'b0;
                        mar_addr <= (arb_grant == GNT_DATA) ? data_addr : fetch_addr;
                        mar_load <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ADDR: begin
`ifdef MEM_WAIT_STATE_EN
                    // Early read strobe gives the RAM address setup time;
                    // the MBR stays idle until XFER.
                    state  <= WAIT;
                    ram_rd <= ~we_q;
`else
                    state        <= XFER;
                    ram_rd       <= ~we_q;
                    mbr_data_src <= we_q;   // capture bus on write, RAM on read
                    mbr_en       <= 1'b1;
`endif
                end
                WAIT: begin
                    state        <= XFER;
                    ram_rd       <= ~we_q;
                    mbr_data_src <= we_q;
                    mbr_en       <= 1'b1;
                end
                XFER: begin
                    state        <= DRIVE;
                    ram_wr       <= we_q;
                    mbr_data_src <= ~we_q;  // drive bus on read, RAM on write
                    mbr_en_read  <= 1'b0;
                    mbr_en       <= 1'b1;
                    fetch_ack    <= (grant_q == GNT_FETCH);
                    data_ack     <= (grant_q == GNT_DATA);
                end
                DRIVE: begin
                    state      <= IDLE;
                    last_grant <= grant_q;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. Control outputs are packed into one
// vector and compared per cycle against hand-derived constants.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic        fetch_ack;
    logic        data_ack;
    logic [15:0] mar_addr;
    logic        mar_load;
    logic        mbr_data_src;
    logic        mbr_en_read;
    logic        mbr_en;
    logic        ram_rd;
    logic        ram_wr;
    logic        busy;

    int checks = 0;
    int passed = 0;

    mem_access_ctrl #(.ADDR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .fetch_ack    (fetch_ack),
        .data_ack     (data_ack),
        .mar_addr     (mar_addr),
        .mar_load     (mar_load),
        .mbr_data_src (mbr_data_src),
        .mbr_en_read  (mbr_en_read),
        .mbr_en       (mbr_en),
        .ram_rd       (ram_rd),
        .ram_wr       (ram_wr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {fetch_ack, data_ack, mar_load, mbr_data_src, mbr_en_read, mbr_en,
    //  ram_rd, ram_wr, busy}
    logic [8:0] ctl;
    assign ctl = {fetch_ack, data_ack, mar_load, mbr_data_src, mbr_en_read,
                  mbr_en, ram_rd, ram_wr, busy};

    localparam logic [8:0] C_IDLE     = 9'b000010000;
    localparam logic [8:0] C_ADDR     = 9'b001010001;
    localparam logic [8:0] C_WAIT_RD  = 9'b000010101;
    localparam logic [8:0] C_WAIT_WR  = 9'b000010001;
    localparam logic [8:0] C_XFER_RD  = 9'b000011101;
    localparam logic [8:0] C_XFER_WR  = 9'b000111001;
    localparam logic [8:0] C_DRV_RD_F = 9'b100101001;
    localparam logic [8:0] C_DRV_RD_D = 9'b010101001;
    localparam logic [8:0] C_DRV_WR_D = 9'b010001011;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        else
            passed++;
    endtask

    task automatic expect_cycle(input string tag, input logic [8:0] exp);
        @(negedge clk);
        check(tag, {23'd0, ctl}, {23'd0, exp});
    endtask

    task automatic drop_req(input logic is_fetch);
        if (is_fetch) fetch_req = 1'b0;
        else          data_req  = 1'b0;
    endtask

    // Called on a falling edge in IDLE with the request already raised.
    // mode 0: normal; 1: scramble address/direction after ADDR;
    // 2: drop the request during XFER.
    task automatic do_access(input string tag, input logic is_fetch,
                             input logic we, input logic [15:0] addr,
                             input int mode);
        expect_cycle({tag, "/addr"}, C_ADDR);
        check({tag, "/mar_addr"}, {16'd0, mar_addr}, {16'd0, addr});
        if (mode == 1) begin
            data_addr  = ~data_addr;
            data_we    = ~data_we;
            fetch_addr = ~fetch_addr;
        end
`ifdef MEM_WAIT_STATE_EN
        expect_cycle({tag, "/wait"}, we ? C_WAIT_WR : C_WAIT_RD);
`endif
        expect_cycle({tag, "/xfer"}, we ? C_XFER_WR : C_XFER_RD);
        if (mode == 2) drop_req(is_fetch);
        expect_cycle({tag, "/drive"},
                     is_fetch ? C_DRV_RD_F : (we ? C_DRV_WR_D : C_DRV_RD_D));
        drop_req(is_fetch);
        expect_cycle({tag, "/idle"}, C_IDLE);
    endtask

    initial begin
        reset      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 16'h1234;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = 16'h0000;

        // Reset held with a pending fetch: everything at reset values.
        repeat (2) @(negedge clk);
        check("rst/ctl", {23'd0, ctl}, {23'd0, C_IDLE});
        check("rst/mar_addr", {16'd0, mar_addr}, 32'd0);
        reset = 1'b1;
        do_access("fetch1", 1'b1, 1'b0, 16'h1234, 0);

        // Data write; address/direction changes after IDLE are ignored.
        data_req  = 1'b1;
        data_we   = 1'b1;
        data_addr = 16'h2050;
        do_access("wr2050", 1'b0, 1'b1, 16'h2050, 1);

        // Contention from reset priority: fetch, data, fetch, data, ...
        reset = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0100;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 16'h3000;
        do_access("rr1", 1'b1, 1'b0, 16'h0100, 0);
        do_access("rr2", 1'b0, 1'b0, 16'h3000, 0);
        fetch_req  = 1'b1;
        fetch_addr = 16'h0200;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 16'h3100;
        do_access("rr3", 1'b1, 1'b0, 16'h0200, 0);
        do_access("rr4", 1'b0, 1'b1, 16'h3100, 0);
        fetch_req  = 1'b1;
        fetch_addr = 16'h0300;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 16'h3200;
        do_access("rr5", 1'b1, 1'b0, 16'h0300, 0);
        do_access("rr6", 1'b0, 1'b0, 16'h3200, 0);

        // Early drop during XFER: cycle completes, nothing re-granted.
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 16'h4444;
        do_access("drop", 1'b0, 1'b0, 16'h4444, 2);
        expect_cycle("drop/no_regrant", C_IDLE);

        // Make fetch the last grant, so only a restored reset priority
        // lets fetch beat data after the reset below.
        fetch_req  = 1'b1;
        fetch_addr = 16'h0F00;
        do_access("pre", 1'b1, 1'b0, 16'h0F00, 0);

        // Reset mid-read: strobes drop asynchronously, no ack.
        fetch_req  = 1'b1;
        fetch_addr = 16'h0ABC;
        expect_cycle("rmid/addr", C_ADDR);
`ifdef MEM_WAIT_STATE_EN
        expect_cycle("rmid/wait", C_WAIT_RD);
`endif
        expect_cycle("rmid/xfer", C_XFER_RD);
        #2 reset = 1'b0;
        #1;
        check("rmid/ram_rd", {31'd0, ram_rd}, 32'd0);
        check("rmid/mbr_en", {31'd0, mbr_en}, 32'd0);
        check("rmid/ctl", {23'd0, ctl}, {23'd0, C_IDLE});
        data_req  = 1'b1;
        data_we   = 1'b1;
        data_addr = 16'h5A5A;
        expect_cycle("rmid/no_ack", C_IDLE);
        reset = 1'b1;
        do_access("rmid/refetch", 1'b1, 1'b0, 16'h0ABC, 0);
        do_access("rmid/data", 1'b0, 1'b1, 16'h5A5A, 0);

        // Boundary addresses.
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 16'h00FF;
        do_access("rd00ff", 1'b0, 1'b0, 16'h00FF, 0);
        fetch_req  = 1'b1;
        fetch_addr = 16'hFFFF;
        do_access("fffff", 1'b1, 1'b0, 16'hFFFF, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
